apb_requester: RTL and testbench

APB requester that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers, driving the APB slave memory port. Sits directly upstream of that slave: its `psel_o`, `penable_o`, `paddr_o`, `pwrite_o` and `pwdata_o` wire to the slave's APB inputs, and the slave's `prdata`/`pready` return here. Each completed transfer produces a one-cycle response pulse carrying read data and an error flag.

---
 rtl/apb_requester.sv | 196 +++++++++++++++++++
 tb/tb_apb_requester.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// apb_requester
//
// Turns a valid/ready command stream into APB SETUP/ACCESS transfers and
// reports every finished transfer with a one-cycle response pulse.
//
// Optional feature macro: APB_REQUESTER_TIMEOUT_EN
//   When defined, an ACCESS phase whose pready_i stays low for TIMEOUT_CYCLES
//   wait cycles is aborted and answered with rsp_err_o=1. When undefined,
//   ACCESS waits indefinitely and rsp_err_o is tied low.
//
// Ports
//   clk, reset     : single clock, synchronous active-high reset
//   cmd_valid_i    : command present
//   cmd_ready_o    : command accepted when cmd_valid_i & cmd_ready_o
//   cmd_write_i    : 1 = write, 0 = read
//   cmd_addr_i     : transfer address
//   cmd_wdata_i    : write data (ignored for reads)
//   rsp_valid_o    : one-cycle pulse per finished transfer
//   rsp_rdata_o    : read data; 0 for writes and errored transfers
//   rsp_err_o      : transfer aborted by timeout (valid with rsp_valid_o)
//   psel_o, penable_o, pwrite_o, paddr_o, pwdata_o : APB request side
//   prdata_i, pready_i                             : APB completion side
// -----------------------------------------------------------------------------
module apb_requester #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_requester: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                cmd_accept;
    logic                xfer_done;
    logic                xfer_abort;

    // A completing ACCESS frees the requester in the same cycle, so a new
    // command can be taken while the old one finishes (combinational from
    // pready_i).
    assign cmd_ready_o = (state_q == IDLE) || ((state_q == ACCESS) && pready_i);
    assign cmd_accept  = cmd_valid_i && cmd_ready_o;
    assign xfer_done   = (state_q == ACCESS) && pready_i;

    assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o   = (state_q == ACCESS);
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

`ifdef APB_REQUESTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rsp_err_q, rsp_err_d;

    // Counter value equals the number of not-ready ACCESS cycles seen so far;
    // clearing it in SETUP makes it zero on the first ACCESS cycle.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == SETUP) begin
            wait_cnt_d = '0;
        end else if ((state_q == ACCESS) && !pready_i) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // pready_i at the limit completes normally: abort needs pready_i low.
    assign xfer_abort = (state_q == ACCESS) && !pready_i &&
                        (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        rsp_err_d = rsp_err_q;
        if (xfer_done) begin
            rsp_err_d = 1'b0;
        end else if (xfer_abort) begin
            rsp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    assign xfer_abort = 1'b0;
    assign rsp_err_o  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (xfer_done) begin
                    state_d = cmd_accept ? SETUP : IDLE;
                end else if (xfer_abort) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Request fields only change on accept, so they stay stable from
        // SETUP through the completing ACCESS and hold while idle.
        if (cmd_accept) begin
            pwrite_d = cmd_write_i;
            paddr_d  = cmd_addr_i;
            pwdata_d = cmd_wdata_i;
        end

        if (xfer_done) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = pwrite_q ? '0 : prdata_i;
        end else if (xfer_abort) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
`timescale 1ns/1ps
// Self-checking bench for apb_requester. A transaction-level reference model
// (accept cycle, fixed SETUP/ACCESS offsets, queue of expected responses)
// predicts every output every cycle; table vectors and short directed
// sequences cover latency, wait states, back-to-back, reset and timeout.
module tb_apb_requester;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_wdata_i;
    logic          rsp_valid_o, rsp_err_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          psel_o, penable_o, pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o, prdata_i;
    logic          pready_i;

    always #5 clk = ~clk;

    apb_requester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o),
        .prdata_i(prdata_i), .pready_i(pready_i)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          cyc      = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    endfunction

    // Reference model: one outstanding transfer described by its accept cycle.
    bit            cur_v;
    int            cur_a;
    logic          m_w;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rdata;
    logic          m_err;
    typedef struct {int t; logic [DW-1:0] rdata; logic err;} rsp_t;
    rsp_t rq[$];

    logic          obs_ready, obs_psel, obs_pen, obs_rv, obs_err;
    logic [DW-1:0] obs_rdata;
    logic [AW-1:0] obs_addr;

    task automatic model_reset();
        cur_v = 0; cur_a = 0; m_w = 1'b0; m_addr = '0; m_wd = '0;
        m_rdata = '0; m_err = 1'b0; rq.delete();
    endtask

    task automatic cycle(input logic rst, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic rdy, input logic [DW-1:0] rd);
        bit in_access, done, abort, exp_ready, exp_rv;
        reset = rst; cmd_valid_i = v; cmd_write_i = w; cmd_addr_i = a;
        cmd_wdata_i = wd; pready_i = rdy; prdata_i = rd;
        @(negedge clk);
        obs_ready = cmd_ready_o; obs_psel = psel_o; obs_pen = penable_o;
        obs_rv = rsp_valid_o; obs_err = rsp_err_o; obs_rdata = rsp_rdata_o; obs_addr = paddr_o;
        if (rst) begin
            model_reset();
        end else begin
            in_access = cur_v && (cyc >= cur_a + 2);
            exp_ready = !cur_v || (in_access && rdy);
            exp_rv    = (rq.size() > 0) && (rq[0].t == cyc);
            if (exp_rv) begin
                m_rdata = rq[0].rdata; m_err = rq[0].err;
                void'(rq.pop_front());
            end
            chk("cmd_ready", obs_ready, exp_ready);
            chk("psel", obs_psel, cur_v && (cyc >= cur_a + 1));
            chk("penable", obs_pen, in_access);
            chk("paddr", obs_addr, m_addr);
            chk("pwrite", pwrite_o, m_w);
            chk("pwdata", pwdata_o, m_wd);
            chk("rsp_valid", obs_rv, exp_rv);
            chk("rsp_rdata", obs_rdata, m_rdata);
            chk("rsp_err", obs_err, m_err);
            done  = in_access && rdy;
            abort = 0;
`ifdef APB_REQUESTER_TIMEOUT_EN
            abort = in_access && !rdy && ((cyc - (cur_a + 2)) == TO);
`endif
            if (done)  rq.push_back('{cyc + 1, (m_w ? {DW{1'b0}} : rd), 1'b0});
            if (abort) rq.push_back('{cyc + 1, {DW{1'b0}}, 1'b1});
            if (done || abort) cur_v = 0;
            if (v && exp_ready) begin
                cur_v = 1; cur_a = cyc; m_w = w; m_addr = a; m_wd = wd;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;
    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int lat; bit seen; bit stable;
        cycle(0, 1, v.write, v.addr, v.wdata, 0, 32'h0);
        lat = 0; seen = 0; stable = 1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            cycle(0, 0, 0, '0, '0, (k == 2 + v.waits),
                  (k == 2 + v.waits) ? v.prdata : (32'hBAD0_0000 + k));
            if (obs_psel && obs_addr !== v.addr) stable = 0;
            if (obs_rv) begin seen = 1; lat = k; end
        end
        chk("vec_rsp_seen", seen, 1);
        chk("vec_latency", lat, v.exp_lat);
        chk("vec_rdata", obs_rdata, v.exp_rdata);
        chk("vec_err", obs_err, 0);
        chk("vec_addr_stable", stable, 1);
    endtask

    int  idx, drops, pulses, acc_cycles;
    bit  seen_rsp;
    logic rdy_r;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0;
        cmd_wdata_i = '0; pready_i = 0; prdata_i = '0;
        model_reset();
        @(posedge clk); #1;

        // Reset for 2 cycles with a command held: it must not be taken.
        cycle(1, 1, 1, 10'h155, 32'h1111_2222, 1, 32'h0);
        cycle(1, 1, 1, 10'h155, 32'h1111_2222, 1, 32'h0);
        cycle(0, 0, 0, '0, '0, 0, 32'h0);
        chk("reset_cmd_ready", obs_ready, 1);
        chk("reset_psel", obs_psel, 0);
        chk("reset_penable", obs_pen, 0);
        chk("reset_rsp_valid", obs_rv, 0);
        chk("reset_rsp_rdata", obs_rdata, 0);
        chk("reset_paddr", obs_addr, 0);
        chk("reset_pwdata", pwdata_o, 0);
        cycle(0, 0, 0, '0, '0, 0, 32'h0);
        chk("reset_no_accept", obs_psel, 0);

        // Table: single transfers with varying wait states.
        vecs[0] = '{1'b1, 10'h004, 32'hDEAD_BEEF, 0, 32'h1234_5678, 32'h0,         3};
        vecs[1] = '{1'b0, 10'h004, 32'h0,         3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 6};
        vecs[2] = '{1'b0, 10'h3FF, 32'h0,         0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3};
        vecs[3] = '{1'b1, 10'h000, 32'hFFFF_FFFF, 1, 32'h0000_0055, 32'h0,         4};
        vecs[4] = '{1'b0, 10'h200, 32'h0,         2, 32'h0,         32'h0,         5};
        vecs[5] = '{1'b0, 10'h0F0, 32'h0,         4, 32'hC0FF_EE00, 32'hC0FF_EE00, 7};
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // pready held low: abort after the limit, or wait forever.
        cycle(0, 1, 0, 10'h1F0, 32'h0, 0, 32'h0);
        acc_cycles = 0; seen_rsp = 0;
`ifdef APB_REQUESTER_TIMEOUT_EN
        for (int k = 0; k < 50 && !seen_rsp; k++) begin
            cycle(0, 0, 0, '0, '0, 0, 32'hFACE_0000);
            if (obs_pen) acc_cycles++;
            if (obs_rv) seen_rsp = 1;
        end
        chk("timeout_rsp_seen", seen_rsp, 1);
        chk("timeout_access_cycles", acc_cycles, TO + 1);
        chk("timeout_err", obs_err, 1);
        chk("timeout_rdata", obs_rdata, 0);
        chk("timeout_idle_psel", obs_psel, 0);
        chk("timeout_idle_ready", obs_ready, 1);
`else
        for (int k = 0; k < 1001; k++) begin
            cycle(0, 0, 0, '0, '0, 0, 32'hFACE_0000);
            if (obs_pen) acc_cycles++;
            if (obs_rv) seen_rsp = 1;
        end
        chk("nohang_no_rsp", seen_rsp, 0);
        chk("nohang_access_cycles", acc_cycles, 1000);
        chk("nohang_still_access", obs_pen, 1);
        cycle(0, 0, 0, '0, '0, 1, 32'h0BAD_F00D);
        cycle(0, 0, 0, '0, '0, 0, 32'h0);
        chk("nohang_late_rsp", obs_rv, 1);
        chk("nohang_late_rdata", obs_rdata, 32'h0BAD_F00D);
`endif

        // Back-to-back writes with cmd_valid held and zero waits.
        idx = 0; drops = 0; pulses = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(0, (idx < 4), 1, idx[AW-1:0], 32'hB000_0000 | idx, 1, 32'h0);
            if (idx < 4 && obs_ready) idx++;
            if (k >= 1 && k <= 8 && !obs_psel) drops++;
            if (obs_rv) pulses++;
        end
        chk("b2b_accepted", idx, 4);
        chk("b2b_psel_drops", drops, 0);
        chk("b2b_pulses", pulses, 4);

        // Reset during a waiting ACCESS.
        cycle(0, 1, 0, 10'h02A, 32'h0, 0, 32'h0);
        cycle(0, 0, 0, '0, '0, 0, 32'h0);
        cycle(0, 0, 0, '0, '0, 0, 32'h0);
        chk("midrst_in_access", obs_pen, 1);
        cycle(1, 0, 0, '0, '0, 0, 32'h0);
        cycle(0, 0, 0, '0, '0, 1, 32'h0);
        chk("midrst_psel", obs_psel, 0);
        chk("midrst_no_rsp", obs_rv, 0);
        chk("midrst_ready", obs_ready, 1);
        cycle(0, 0, 0, '0, '0, 1, 32'h0);
        chk("midrst_no_rsp2", obs_rv, 0);

        // Randomized traffic against the model; the second half starves pready.
        for (int i = 0; i < 1500; i++) begin
            rdy_r = (i < 750) ? 1'(($urandom % 4) != 0) : 1'(($urandom % 5) == 0);
            cycle(1'(($urandom % 150) == 0), 1'($urandom % 2), 1'($urandom % 2),
                  AW'($urandom), $urandom, rdy_r, $urandom);
        end
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, '0, '0, 1, 32'h0);
        chk("drain_queue_empty", rq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
